// File: rtl/zbc_pkg.sv
`default_nettype none
// ============================================================================
// zbc_pkg : shared sizing helpers and zero-byte reference count for zbc_share_sched
// Revision: 1.0 - initial release
// ============================================================================
package zbc_pkg;

  localparam int ZBC_MAX_W     = 1024;
  localparam int ZBC_ACC_W_DEF = 16;
  localparam logic [ZBC_ACC_W_DEF-1:0] ZBC_ACC_SAT = '1;

  function automatic int zbc_lanes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int zbc_cnt_w(input int data_w);
    return $clog2(data_w / 8 + 1);
  endfunction

  function automatic int zbc_id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Reference count of all-zero bytes among the low data_w bits of word.
  function automatic int zbc_count(input logic [ZBC_MAX_W-1:0] word, input int data_w);
    int n;
    n = 0;
    for (int k = 0; k < ZBC_MAX_W / 8; k++) begin
      if ((k < data_w / 8) && (word[8*k +: 8] == 8'h00)) n++;
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/zero_byte_counter.sv
`default_nettype none
// ============================================================================
// zero_byte_counter : per-byte NOR flags reduced to a popcount of zero bytes
// Revision: 1.0 - initial release
// ============================================================================
module zero_byte_counter
  import zbc_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int LANES  = zbc_lanes(DATA_W),
  localparam int CNT_W  = zbc_cnt_w(DATA_W)
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [CNT_W-1:0]  count_o
);

  logic [LANES-1:0] w_zero;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_zero[k] = ~|data_i[8*k +: 8];
  end

  always_comb begin
    count_o = '0;
    for (int k = 0; k < LANES; k++) begin
      count_o = count_o + CNT_W'(w_zero[k]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/zbc_share_sched.sv
`default_nettype none
// ============================================================================
// zbc_share_sched : round-robin share of one zero-byte-count datapath among
//                   NUM_REQ requesters; optional per-requester accumulators
//                   enabled by defining ZBC_ACCUM_EN.
// Revision: 1.0 - initial release
// ============================================================================
module zbc_share_sched
  import zbc_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 32,
  parameter  int ACC_W   = 16,
  localparam int CNT_W   = zbc_cnt_w(DATA_W),
  localparam int ID_W    = zbc_id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [CNT_W-1:0]          rsp_count,
  input  logic                      acc_clr,
  output logic [ACC_W-1:0]          rsp_acc
);

  // Stage 1: operand register
  logic              v1_q, v1_d;
  logic [ID_W-1:0]   id1_q, id1_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  // Stage 2: result register
  logic              v2_q, v2_d;
  logic [ID_W-1:0]   id2_q, id2_d;
  logic [CNT_W-1:0]  cnt2_q, cnt2_d;

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic              w_adv2;
  logic              w_accept;
  logic              w_fire;
  logic              w_gnt_vld;
  logic [ID_W-1:0]   w_gnt_id;
  logic [ID_W-1:0]   w_scan_idx;
  logic [CNT_W-1:0]  w_cnt;
  logic [DATA_W-1:0] w_words [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign w_words[i] = req_data[i*DATA_W +: DATA_W];
  end

  assign w_adv2   = v1_q & (~v2_q | rsp_ready);
  assign w_accept = ~v1_q | w_adv2;
  assign w_fire   = w_accept & w_gnt_vld;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_id   = '0;
    w_scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!w_gnt_vld && req_valid[w_scan_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_scan_idx;
      end
    end
  end

  // Gated by rst_n so no requester sees an accept while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && w_fire) req_ready[w_gnt_id] = 1'b1;
  end

  zero_byte_counter #(
    .DATA_W (DATA_W)
  ) u_zbc (
    .data_i  (data1_q),
    .count_o (w_cnt)
  );

  always_comb begin
    v1_d     = v1_q;
    id1_d    = id1_q;
    data1_d  = data1_q;
    rr_ptr_d = rr_ptr_q;
    if (w_fire) begin
      v1_d     = 1'b1;
      id1_d    = w_gnt_id;
      data1_d  = w_words[w_gnt_id];
      rr_ptr_d = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
    end else if (w_adv2) begin
      v1_d = 1'b0;
    end

    v2_d   = v2_q;
    id2_d  = id2_q;
    cnt2_d = cnt2_q;
    if (w_adv2) begin
      v2_d   = 1'b1;
      id2_d  = id1_q;
      cnt2_d = w_cnt;
    end else if (rsp_ready) begin
      v2_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      id1_q    <= '0;
      data1_q  <= '0;
      v2_q     <= 1'b0;
      id2_q    <= '0;
      cnt2_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      v1_q     <= v1_d;
      id1_q    <= id1_d;
      data1_q  <= data1_d;
      v2_q     <= v2_d;
      id2_q    <= id2_d;
      cnt2_q   <= cnt2_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rsp_valid = v2_q;
  assign rsp_id    = id2_q;
  assign rsp_count = cnt2_q;

`ifdef ZBC_ACCUM_EN
  logic [ACC_W-1:0] acc_q [NUM_REQ];
  logic [ACC_W:0]   w_acc_sum;
  logic [ACC_W-1:0] w_acc_sat;
  logic             w_rsp_hs;

  assign w_rsp_hs  = v2_q & rsp_ready;
  assign w_acc_sum = {1'b0, acc_q[id2_q]} + (ACC_W+1)'(cnt2_q);
  assign w_acc_sat = w_acc_sum[ACC_W] ? '1 : w_acc_sum[ACC_W-1:0];
  assign rsp_acc   = w_acc_sat;

  // A clear coinciding with a handshake keeps only the current result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_rsp_hs && (id2_q == ID_W'(i))) begin
          acc_q[i] <= acc_clr ? ACC_W'(cnt2_q) : w_acc_sat;
        end else if (acc_clr) begin
          acc_q[i] <= '0;
        end
      end
    end
  end
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;
  assign rsp_acc        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_zbc_share_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_zbc_share_sched : scoreboard bench for zbc_share_sched
// Revision: 1.0 - initial release
// ============================================================================
module tb_zbc_share_sched;
  import zbc_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ACC_W   = 4;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   rq_valid;
  logic [31:0]  rq_data [4];
  logic [127:0] req_data_bus;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [2:0]   rsp_count;
  logic         acc_clr;
  logic [3:0]   rsp_acc;

  assign req_data_bus = {rq_data[3], rq_data[2], rq_data[1], rq_data[0]};

  zbc_share_sched #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (rq_valid),
    .req_ready (req_ready),
    .req_data  (req_data_bus),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .acc_clr   (acc_clr),
    .rsp_acc   (rsp_acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   mptr   = 0;
  int   macc [4];
  int   glog[$];
  int   acc_seen[$];
  int   ngrant = 0;
  int   last_id, last_cnt;
  bit   log_acc = 1'b0;
  exp_t mon_e;
  int   mon_g, mon_idx, mon_exp_acc;
  logic [ZBC_MAX_W-1:0] mon_word;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: grant model pushes expectations, response handshakes pop them.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      mptr = 0;
      foreach (macc[i]) macc[i] = 0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", int'(rsp_id), -1);
        end else begin
          mon_e = sbq.pop_front();
          chk("rsp_id", int'(rsp_id), mon_e.id);
          chk("rsp_count", int'(rsp_count), mon_e.cnt);
`ifdef ZBC_ACCUM_EN
          mon_exp_acc = macc[mon_e.id] + mon_e.cnt;
          if (mon_exp_acc > ACC_MAX) mon_exp_acc = ACC_MAX;
          chk("rsp_acc", int'(rsp_acc), mon_exp_acc);
          if (acc_clr) begin
            foreach (macc[i]) macc[i] = 0;
            macc[mon_e.id] = mon_e.cnt;
          end else begin
            macc[mon_e.id] = mon_exp_acc;
          end
`else
          chk("rsp_acc", int'(rsp_acc), 0);
`endif
          last_id  = int'(rsp_id);
          last_cnt = int'(rsp_count);
          if (log_acc) acc_seen.push_back(int'(rsp_acc));
        end
      end
`ifdef ZBC_ACCUM_EN
      else if (acc_clr) begin
        foreach (macc[i]) macc[i] = 0;
      end
`endif
      if (req_ready != 4'b0000) begin
        mon_g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
          mon_idx = (mptr + k) % NUM_REQ;
          if (mon_g < 0 && rq_valid[mon_idx]) mon_g = mon_idx;
        end
        if (mon_g < 0) begin
          chk("grant_without_valid", int'(req_ready), 0);
        end else begin
          chk("grant_onehot", int'(req_ready), 1 << mon_g);
          mon_word = ZBC_MAX_W'(rq_data[mon_g]);
          sbq.push_back('{mon_g, zbc_count(mon_word, DATA_W)});
          mptr = (mon_g + 1) % NUM_REQ;
          glog.push_back(mon_g);
          ngrant++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 50) begin
      tick();
      t++;
    end
    chk("drain_pending", sbq.size(), 0);
  endtask

  task automatic send_one(input int id, input logic [31:0] d, input bit clr);
    int t;
    rq_data[id]  = d;
    rq_valid[id] = 1'b1;
    #1;
    t = 0;
    while (!req_ready[id] && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) chk("grant_timeout", t, 0);
    tick();
    rq_valid[id] = 1'b0;
    t = 0;
    while (!rsp_valid && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) chk("rsp_timeout", t, 0);
    acc_clr = clr;
    tick();
    acc_clr = 1'b0;
  endtask

  int exp3 [6];
  int exp5 [7];
  int g0;

  initial begin
    rq_valid  = '0;
    foreach (rq_data[i]) rq_data[i] = '0;
    rsp_ready = 1'b1;
    acc_clr   = 1'b0;
    rst_n     = 1'b0;
    repeat (3) tick();

    // Reset state, including a requester valid while reset is held
    rq_valid = 4'b0001;
    #1;
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_rsp_count", int'(rsp_count), 0);
    chk("rst_rsp_acc", int'(rsp_acc), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    rq_valid = '0;
    rst_n    = 1'b1;
    tick();

    // 1: single requester latency
    rq_data[0] = 32'h00FF0000;
    rq_valid   = 4'b0001;
    #1;
    chk("t1_ready", int'(req_ready), 1);
    tick();
    rq_valid = '0;
    chk("t1_valid_T1", int'(rsp_valid), 0);
    tick();
    chk("t1_valid_T2", int'(rsp_valid), 1);
    chk("t1_id", int'(rsp_id), 0);
    chk("t1_count", int'(rsp_count), 3);
    drain();

    // 2: directed words through requester 3 (leaves rr_ptr at 0)
    send_one(3, 32'h00000000, 1'b0);
    chk("t2_zero_cnt", last_cnt, 4);
    chk("t2_zero_id", last_id, 3);
    send_one(3, 32'h01010101, 1'b0);
    chk("t2_0101_cnt", last_cnt, 0);
    send_one(3, 32'hFF00FF00, 1'b0);
    chk("t2_ff00_cnt", last_cnt, 2);

    // 3: all requesters continuously valid
    rq_data[0] = 32'h00FF0000;
    rq_data[1] = 32'h00000000;
    rq_data[2] = 32'h01010101;
    rq_data[3] = 32'hFF00FF00;
    exp3 = '{0, 1, 2, 3, 0, 1};
    glog.delete();
    rq_valid = 4'b1111;
    repeat (6) tick();
    rq_valid = '0;
    chk("t3_grants", glog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < glog.size()) chk("t3_order", glog[i], exp3[i]);
    end
    drain();

    // 4: response stall from idle; rr_ptr is 2 here
    rsp_ready = 1'b0;
    g0        = ngrant;
    rq_valid  = 4'b1111;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i >= 2) begin
        chk("t4_hold_valid", int'(rsp_valid), 1);
        chk("t4_hold_id", int'(rsp_id), 2);
        chk("t4_hold_count", int'(rsp_count), 0);
        chk("t4_no_ready", int'(req_ready), 0);
      end
    end
    chk("t4_stall_accepts", ngrant - g0, 2);
    rsp_ready = 1'b1;
    repeat (4) tick();
    rq_valid = '0;
    drain();

    // 5: accumulator with saturation and clear
    acc_seen.delete();
    log_acc = 1'b1;
    for (int i = 0; i < 5; i++) send_one(2, 32'h00000000, 1'b0);
    send_one(2, 32'h00000000, 1'b1);
    send_one(2, 32'h01010101, 1'b0);
    log_acc = 1'b0;
`ifdef ZBC_ACCUM_EN
    exp5 = '{4, 8, 12, 15, 15, 15, 4};
`else
    exp5 = '{0, 0, 0, 0, 0, 0, 0};
`endif
    chk("t5_rsp_num", acc_seen.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < acc_seen.size()) chk("t5_rsp_acc", acc_seen[i], exp5[i]);
    end

    // 6: reset with both stages full
    rsp_ready  = 1'b0;
    rq_data[0] = 32'h00FF0000;
    rq_valid   = 4'b0001;
    repeat (3) tick();
    chk("t6_pre_valid", int'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(rsp_valid), 0);
    chk("t6_rst_ready", int'(req_ready), 0);
    chk("t6_rst_id", int'(rsp_id), 0);
    tick();
    tick();
    rq_valid  = 4'b1010;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    chk("t6_first_grant", int'(req_ready), 4'b0010);
    tick();
    chk("t6_second_grant", int'(req_ready), 4'b1000);
    tick();
    rq_valid = '0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
